vga_cpu_arbiter: RTL and testbench
==================================

// Module: vga_cpu_arbiter
// PURPOSE
//  Schedules CPU accesses to the 4-byte-wide video RAM into gaps between video fetches.
//  Sits beside the VGA timing generator: it holds the CPU with rdy, muxes the CPU address
//  onto the RAM, and drives CS/WE, the transceiver enables and a read-data latch strobe.
//  The video fetch always wins unless the steal option is compiled in.
// PARAMETERS
//  STROBE_CYCLES  2    clocks that CS (and WE on writes) stay low; range 1..8
//  MAX_WAIT       200  clocks waited for a gap before stealing (used only with VGA_CPU_STEAL_EN)
// PORTS
//  clock          in   1  50 MHz system clock
//  _reset         in   1  synchronous reset, active low
//  _vga_mem       in   1  CPU cycle targets video memory, active low
//  addr           in   2  A0-A1 from the system address bus
//  _rd            in   1  CPU read strobe, active low
//  _wr            in   1  CPU write strobe, active low
//  _bhe           in   1  CPU byte-high enable, active low
//  vid_gap        in   4  clocks until the next video RAM fetch (15 = 15 or more / blanking)
//  rdy            out  1  CPU READY; low = insert wait states
//  _cs_ram_cpu    out  4  per-byte RAM CS for CPU cycles; ANDed with the video CS on the board
//  _we_ram        out  4  per-byte RAM WE, active low
//  _cpu_ram_addr  out  1  CPU address bus drives RAM address, active low
//  _cpu_ram       out  4  per-byte CPU<->RAM transceiver enables, active low
//  cpu_ram_dir    out  1  transceiver direction: 1 = CPU to RAM, 0 = RAM to CPU
//  cpu_rd_latch   out  1  one-clock pulse that captures RAM read data into the CPU-side latch
//  vid_inhibit    out  1  timing generator suppresses its fetch while this is high
// BEHAVIOUR
//  - CPU inputs pass through a 2-flop synchronizer first: req = ~_vga_mem & (~_rd ^ ~_wr).
//    _rd and _wr both low is illegal: no request, and the FSM stays in IDLE.
//  - rdy is combinational: rdy = ~(raw_req & state!=DONE). It drops in the same clock as the
//    raw strobe, before synchronization.
//  - Lane mask: lo=~addr[0], hi=~_bhe. lane = {a1&hi, a1&lo, ~a1&hi, ~a1&lo}.
//    Lane mask and direction are captured on the IDLE->WAIT_GAP transition.
//  - FSM states and transitions:
//      IDLE:     synced req -> WAIT_GAP.
//      WAIT_GAP: vid_gap >= STROBE_CYCLES+2 -> SETUP.
//      SETUP:    1 clock; _cpu_ram_addr=0, _cpu_ram=~lane, dir set.
//      STROBE:   STROBE_CYCLES clocks; _cs_ram_cpu=~lane; _we_ram=~lane only on writes.
//      HOLD:     1 clock; CS/WE high, addr and transceivers held (write hold time).
//                cpu_rd_latch pulses in the last STROBE clock of a read.
//      DONE:     rdy high; wait for synced req to fall -> IDLE.
//  - Lane mask 0 (A0=1 with _bhe=1): runs the full sequence with no CS/WE/transceiver
//    asserted, so the CPU still completes its cycle.
//  - vid_gap is sampled only in WAIT_GAP. Later changes are the timing generator's
//    responsibility; the gap test guarantees SETUP..HOLD fits in the gap.
//  - Reset values (also when reset is taken mid-operation, effective next clock):
//      state = IDLE, rdy = 1, every active-low output = all ones,
//      cpu_ram_dir = 0, cpu_rd_latch = 0, vid_inhibit = 0, wait counter = 0.
//  - Back-to-back CPU cycles: a new access starts only after passing through IDLE.
// CONFIGURATION
//  VGA_CPU_STEAL_EN defined: a wait counter counts clocks in WAIT_GAP. At MAX_WAIT the FSM
//    goes to SETUP regardless of vid_gap, with vid_inhibit=1 from SETUP through HOLD.
//    This bounds CPU latency at the cost of a one-glyph display glitch.
//  Not defined: WAIT_GAP waits indefinitely; vid_inhibit is tied to 0 and the counter is
//    not built.
// STRUCTURE
//  - vga_pkg: FSM state enum, lane-decode function, the video mode constants
//    (0 text, 1 320x200, 2 320x400, 3 400x300) and the vid_gap saturation value 15.
//  - Sub-module vga_cpu_sync: 2-flop synchronizer for _vga_mem/_rd/_wr. It outputs synced
//    req and is_write.
// TESTING
//  1 Byte write A1=0,A0=0,_bhe=1, vid_gap=15: _we_ram=1110 for 2 clocks, dir=1;
//    rdy high in DONE; IDLE again after _wr rises.
//  2 Word read A1=1,A0=0,_bhe=0: _cs_ram_cpu=0011 for 2 clocks, dir=0, one cpu_rd_latch
//    pulse, _we_ram stays 1111.
//  3 Request with vid_gap=3 held 40 clocks then 15: stays in WAIT_GAP with rdy=0 for
//    40 clocks; SETUP on the clock after the gap opens.
//  4 _rd and _wr both low with _vga_mem=0: FSM stays IDLE, no strobes.
//    A0=1,_bhe=1 read: cycle completes, all lane outputs stay 1111.
//  5 _reset low during STROBE: next clock all outputs at reset values, rdy=1;
//    after release a fresh request completes normally.
//  6 VGA_CPU_STEAL_EN, MAX_WAIT=200, vid_gap=0 held: SETUP after 200 clocks in WAIT_GAP,
//    vid_inhibit=1 for 4 clocks. Without the macro: rdy stays 0 for 1000 clocks.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_pkg: arbiter FSM states, byte-lane decode and video mode constants. rev 1.0
// ---------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_GAP = 3'd1,
        ST_SETUP    = 3'd2,
        ST_STROBE   = 3'd3,
        ST_HOLD     = 3'd4,
        ST_DONE     = 3'd5
    } arb_state_t;

    localparam logic [1:0] MODE_TEXT    = 2'd0;
    localparam logic [1:0] MODE_320X200 = 2'd1;
    localparam logic [1:0] MODE_320X400 = 2'd2;
    localparam logic [1:0] MODE_400X300 = 2'd3;

    localparam logic [3:0] VID_GAP_SAT  = 4'd15;

    // Byte lanes of the 32-bit RAM word touched by a 16-bit CPU cycle.
    function automatic logic [3:0] lane_decode(input logic [1:0] a, input logic bhe_n);
        logic lo;
        logic hi;
        lo = ~a[0];
        hi = ~bhe_n;
        return {a[1] & hi, a[1] & lo, ~a[1] & hi, ~a[1] & lo};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_cpu_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_cpu_sync: 2-flop synchronizer for the CPU strobes; yields req and is_write. rev 1.0
// ---------------------------------------------------------------------------
module vga_cpu_sync (
    input  logic clock,
    input  logic _reset,
    input  logic vga_mem_n,
    input  logic rd_n,
    input  logic wr_n,
    output logic req,
    output logic is_write
);

    logic [2:0] stage1;
    logic [2:0] stage2;

    always_ff @(posedge clock) begin
        if (!_reset) begin
            stage1 <= 3'b111;
            stage2 <= 3'b111;
        end else begin
            stage1 <= {vga_mem_n, rd_n, wr_n};
            stage2 <= stage1;
        end
    end

    // Exactly one of read/write must be active; both low is an illegal bus state.
    assign req      = ~stage2[2] & (stage2[1] ^ stage2[0]);
    assign is_write = ~stage2[0];

endmodule
`default_nettype wire

// File: rtl/vga_cpu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_cpu_arbiter: slots CPU accesses into video RAM fetch gaps. rev 1.0
// Define VGA_CPU_STEAL_EN to steal a slot after MAX_WAIT clocks of waiting.
// ---------------------------------------------------------------------------
module vga_cpu_arbiter
    import vga_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int MAX_WAIT      = 200
) (
    input  logic       clock,
    input  logic       _reset,
    input  logic       _vga_mem,
    input  logic [1:0] addr,
    input  logic       _rd,
    input  logic       _wr,
    input  logic       _bhe,
    input  logic [3:0] vid_gap,
    output logic       rdy,
    output logic [3:0] _cs_ram_cpu,
    output logic [3:0] _we_ram,
    output logic       _cpu_ram_addr,
    output logic [3:0] _cpu_ram,
    output logic       cpu_ram_dir,
    output logic       cpu_rd_latch,
    output logic       vid_inhibit
);

    localparam logic [3:0] GAP_NEED = 4'(STROBE_CYCLES + 2);
    localparam logic [2:0] STB_LAST = 3'(STROBE_CYCLES - 1);

    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 8 || MAX_WAIT < 1) begin : g_param_check
        $error("vga_cpu_arbiter: parameter out of range");
    end

    arb_state_t state;
    arb_state_t state_nx;
    logic       req;
    logic       is_write;
    logic       raw_req;
    logic       steal_go;
    logic       in_access;
    logic [3:0] lane;
    logic       write_cyc;
    logic [2:0] stb_cnt;

    vga_cpu_sync u_sync (
        .clock     (clock),
        ._reset    (_reset),
        .vga_mem_n (_vga_mem),
        .rd_n      (_rd),
        .wr_n      (_wr),
        .req       (req),
        .is_write  (is_write)
    );

    // rdy must drop in the same clock as the raw strobe, so it bypasses the synchronizer.
    assign raw_req   = ~_vga_mem & (_rd ^ _wr);
    assign rdy       = ~_reset | ~(raw_req & (state != ST_DONE));
    assign in_access = (state == ST_SETUP) | (state == ST_STROBE) | (state == ST_HOLD);

    always_ff @(posedge clock) begin
        if (!_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clock) begin
        if (!_reset) begin
            lane      <= 4'h0;
            write_cyc <= 1'b0;
            stb_cnt   <= 3'd0;
        end else begin
            if (state == ST_IDLE && req) begin
                lane      <= lane_decode(addr, _bhe);
                write_cyc <= is_write;
            end
            if (state == ST_STROBE && state_nx == ST_STROBE) begin
                stb_cnt <= stb_cnt + 3'd1;
            end else begin
                stb_cnt <= 3'd0;
            end
        end
    end

`ifdef VGA_CPU_STEAL_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              stolen;

    assign steal_go = (wait_cnt == WAIT_LAST) & (vid_gap < GAP_NEED);

    always_ff @(posedge clock) begin
        if (!_reset) begin
            wait_cnt <= '0;
            stolen   <= 1'b0;
        end else begin
            if (state == ST_WAIT_GAP && state_nx == ST_WAIT_GAP) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (state == ST_WAIT_GAP) begin
                stolen <= steal_go;
            end else if (state == ST_IDLE) begin
                stolen <= 1'b0;
            end
        end
    end

    assign vid_inhibit = stolen & in_access;
`else
    assign steal_go    = 1'b0;
    assign vid_inhibit = 1'b0;
`endif

    always_comb begin
        state_nx      = state;
        _cs_ram_cpu   = 4'hF;
        _we_ram       = 4'hF;
        _cpu_ram_addr = 1'b1;
        _cpu_ram      = 4'hF;
        cpu_ram_dir   = 1'b0;
        cpu_rd_latch  = 1'b0;

        case (state)
            ST_IDLE:     if (req) state_nx = ST_WAIT_GAP;
            ST_WAIT_GAP: if (vid_gap >= GAP_NEED || steal_go) state_nx = ST_SETUP;
            ST_SETUP:    state_nx = ST_STROBE;
            ST_STROBE:   if (stb_cnt == STB_LAST) state_nx = ST_HOLD;
            ST_HOLD:     state_nx = ST_DONE;
            ST_DONE:     if (!req) state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase

        // Address mux and transceivers span SETUP..HOLD to cover setup and hold time.
        if (in_access) begin
            _cpu_ram_addr = 1'b0;
            _cpu_ram      = ~lane;
            cpu_ram_dir   = write_cyc;
        end
        if (state == ST_STROBE) begin
            _cs_ram_cpu  = ~lane;
            _we_ram      = write_cyc ? ~lane : 4'hF;
            cpu_rd_latch = ~write_cyc & (stb_cnt == STB_LAST);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_cpu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_cpu_arbiter: self-checking bench with a timeline reference model. rev 1.0
// ---------------------------------------------------------------------------
module tb_vga_cpu_arbiter;

    localparam int SC = 2;
    localparam int MW = 200;
    // {rdy, cs, we, addr_n, ram_n, dir, latch, inhibit} when nothing is happening
    localparam logic [16:0] IDLE_V = {1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0};

    logic       clock = 1'b0;
    logic       reset_n;
    logic       vga_mem_n;
    logic [1:0] addr;
    logic       rd_n;
    logic       wr_n;
    logic       bhe_n;
    logic [3:0] vid_gap;
    logic       rdy;
    logic [3:0] cs_n;
    logic [3:0] we_n;
    logic       cpu_addr_n;
    logic [3:0] cpu_ram_n;
    logic       dir;
    logic       rd_latch;
    logic       vid_inh;

    int checks = 0;
    int errors = 0;

    always #10 clock = ~clock;

    vga_cpu_arbiter #(.STROBE_CYCLES(SC), .MAX_WAIT(MW)) dut (
        .clock         (clock),
        ._reset        (reset_n),
        ._vga_mem      (vga_mem_n),
        .addr          (addr),
        ._rd           (rd_n),
        ._wr           (wr_n),
        ._bhe          (bhe_n),
        .vid_gap       (vid_gap),
        .rdy           (rdy),
        ._cs_ram_cpu   (cs_n),
        ._we_ram       (we_n),
        ._cpu_ram_addr (cpu_addr_n),
        ._cpu_ram      (cpu_ram_n),
        .cpu_ram_dir   (dir),
        .cpu_rd_latch  (rd_latch),
        .vid_inhibit   (vid_inh)
    );

    function automatic logic [16:0] obs();
        return {rdy, cs_n, we_n, cpu_addr_n, cpu_ram_n, dir, rd_latch, vid_inh};
    endfunction

    // One CPU access from strobe to release. Timeline model: two synchronizer clocks,
    // one clock to leave IDLE, then WAIT_GAP until the gap is big enough (or stolen),
    // then SETUP, SC strobe clocks, HOLD, and DONE. Edge numbers count from the strobe.
    task automatic run_access(input string name, input bit wr, input logic [1:0] a,
                              input bit bhe, input int bad_n, input logic [3:0] bad_val,
                              input logic [3:0] good_val);
        int          s_edge;
        int          last;
        bit          stolen;
        logic [3:0]  lane;
        logic        in_win;
        logic        in_stb;
        logic [16:0] exp;
        lane = 4'h0;
        if (a[0] == 1'b0) lane = lane | 4'(1 << (2 * int'(a[1])));
        if (!bhe)         lane = lane | 4'(1 << (2 * int'(a[1]) + 1));
        s_edge = (bad_n + 1 > 4) ? bad_n + 1 : 4;
        stolen = 1'b0;
`ifdef VGA_CPU_STEAL_EN
        if (3 + MW < s_edge) begin
            s_edge = 3 + MW;
            stolen = 1'b1;
        end
`endif
        last = s_edge + SC + 2;
        addr      = a;
        bhe_n     = bhe;
        vga_mem_n = 1'b0;
        rd_n      = wr;
        wr_n      = !wr;
        vid_gap   = (bad_n > 0) ? bad_val : good_val;
        #1;
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s rdy_drop: got %b want 0", name, rdy);
        end
        for (int e = 1; e <= last; e++) begin
            @(posedge clock);
            #1;
            if (e == bad_n) vid_gap = good_val;
            in_win = (e >= s_edge) && (e <= s_edge + SC + 1);
            in_stb = (e >= s_edge + 1) && (e <= s_edge + SC);
            exp = {logic'(e == last),
                   in_stb ? ~lane : 4'hF,
                   (in_stb && wr) ? ~lane : 4'hF,
                   !in_win,
                   in_win ? ~lane : 4'hF,
                   logic'(in_win && wr),
                   logic'(!wr && e == s_edge + SC),
                   logic'(in_win && stolen)};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL %s edge %0d: got %h want %h", name, e, obs(), exp);
            end
        end
        vga_mem_n = 1'b1;
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        vid_gap   = 4'd15;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (obs() !== IDLE_V) begin
                errors++;
                $display("FAIL %s release %0d: got %h want %h", name, i, obs(), IDLE_V);
            end
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        vga_mem_n = 1'b0;
        rd_n      = 1'b0;
        wr_n      = 1'b1;
        addr      = 2'b00;
        bhe_n     = 1'b0;
        vid_gap   = 4'd15;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (obs() !== IDLE_V) begin
                errors++;
                $display("FAIL reset %0d: got %h want %h", i, obs(), IDLE_V);
            end
        end
        vga_mem_n = 1'b1;
        rd_n      = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (obs() !== IDLE_V) begin
                errors++;
                $display("FAIL reset_release %0d: got %h want %h", i, obs(), IDLE_V);
            end
        end
    endtask

    task automatic test_byte_write();
        run_access("byte_write", 1'b1, 2'b00, 1'b1, 0, 4'd0, 4'd15);
    endtask

    task automatic test_word_read();
        run_access("word_read", 1'b0, 2'b10, 1'b0, 0, 4'd0, 4'd15);
    endtask

    task automatic test_gap_wait();
        run_access("gap_wait40", 1'b0, 2'b00, 1'b0, 40, 4'd3, 4'd15);
        run_access("gap_boundary", 1'b1, 2'b10, 1'b1, 6, 4'(SC + 1), 4'(SC + 2));
    endtask

    task automatic test_illegal();
        vga_mem_n = 1'b0;
        rd_n      = 1'b0;
        wr_n      = 1'b0;
        addr      = 2'b01;
        #1;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL illegal rdy: got %b want 1", rdy);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (obs() !== IDLE_V) begin
                errors++;
                $display("FAIL illegal %0d: got %h want %h", i, obs(), IDLE_V);
            end
        end
        vga_mem_n = 1'b1;
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        run_access("lane_zero", 1'b0, 2'b01, 1'b1, 0, 4'd0, 4'd15);
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen      = 1'b0;
        addr      = 2'b10;
        bhe_n     = 1'b0;
        vid_gap   = 4'd15;
        vga_mem_n = 1'b0;
        rd_n      = 1'b1;
        wr_n      = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clock);
            #1;
            if (cs_n !== 4'hF) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid strobe_timeout: got cs %h want active", cs_n);
        end
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (obs() !== IDLE_V) begin
            errors++;
            $display("FAIL reset_mid: got %h want %h", obs(), IDLE_V);
        end
        vga_mem_n = 1'b1;
        wr_n      = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        run_access("after_reset", 1'b1, 2'b01, 1'b0, 0, 4'd0, 4'd15);
    endtask

    task automatic test_steal();
        // Without stealing the CPU waits out all 1000 bad-gap clocks; with it, MW clocks.
        run_access("steal", 1'b0, 2'b00, 1'b1, 1000, 4'd0, 4'd15);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            run_access("random", 1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
                       int'($urandom_range(0, 8)), 4'($urandom_range(0, SC + 1)),
                       4'($urandom_range(SC + 2, 15)));
        end
    endtask

    task automatic test_back_to_back();
        run_access("b2b_write", 1'b1, 2'b10, 1'b0, 0, 4'd0, 4'd15);
        run_access("b2b_read", 1'b0, 2'b10, 1'b0, 0, 4'd0, 4'd15);
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_word_read();
        test_gap_wait();
        test_illegal();
        test_reset_mid();
        test_steal();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
